sd_write_interface: RTL and testbench

- Bus-side write path for the SD card, mirroring the existing read interface.
- The CPU fills a 128-word (512-byte) sector buffer, then writes the target sector address to start a transfer.
- The block streams the buffer byte-by-byte to the SD controller's write port.
- It exposes a busy/done/error status word on the shared memory-mapped data bus.

---
 rtl/sd_write_interface.sv | 170 +++++++++++++++++
 tb/tb_sd_write_interface.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_write_interface.sv
// sd_write_interface: memory-mapped write path for the SD card.
// The CPU fills a 128-word sector buffer, then writes the sector address to
// start a transfer; the buffer is streamed byte-by-byte to the SD controller.

// One byte lane of the sector buffer: a bus write port, a bus read port and
// a stream read port for the byte being sent.
module sd_wr_lane #(
  parameter int DEPTH = 128,
  parameter int AW    = 7,
  parameter int W     = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b
);
  logic [W-1:0] mem [DEPTH];

  // Buffer contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

module sd_write_interface #(
  parameter logic [31:0] SD_WR_ADDR     = 32'hFFFF_0260,
  parameter logic [31:0] SD_WR_CTRL     = 32'hFFFF_0264,
  parameter logic [31:0] WR_BUF_BASE    = 32'hFFFF_0400,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000
) (
  input  logic        iCLK,
  input  logic        Reset_n,
  input  logic        wReadEnable,
  input  logic        wWriteEnable,
  input  logic [3:0]  wByteEnable,
  input  logic [31:0] wAddress,
  input  logic [31:0] wWriteData,
  output logic [31:0] wReadData,
  output logic        oSDWr,
  output logic [31:0] oSDAddress,
  output logic [7:0]  oSDDin,
  input  logic        iSDByteTaken,
  input  logic        iSDIdle,
  input  logic        iSDErr
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 8;
  localparam logic [23:0] TMO_LAST = TIMEOUT_CYCLES - 24'd1;

  typedef enum logic [1:0] {IDLE, REQ, SEND, FINISH} state_t;

  state_t      state;
  logic [8:0]  byte_idx;
  logic [23:0] tmo_cnt;
  logic        busy, done, err, err_seen;

  logic [NUM_LANES-1:0][VEC_W-1:0] bus_word;
  logic [NUM_LANES-1:0][VEC_W-1:0] stream_word;

  logic buf_hit, ctrl_hit, buf_we, trig, tmo_hit;

  assign buf_hit  = (wAddress >= WR_BUF_BASE) && (wAddress <= WR_BUF_BASE + 32'h1FC);
  assign ctrl_hit = (wAddress == SD_WR_CTRL);
  assign buf_we   = wWriteEnable && buf_hit && !busy;
  assign trig     = wWriteEnable && (wAddress == SD_WR_ADDR) && (state == IDLE);
  assign tmo_hit  = (tmo_cnt == TMO_LAST);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sd_wr_lane #(.DEPTH(128), .AW(7), .W(VEC_W)) u_lane (
      .clk     (iCLK),
      .we      (buf_we && wByteEnable[i]),
      .waddr   (wAddress[8:2]),
      .wdata   (wWriteData[i*VEC_W +: VEC_W]),
      .raddr_a (wAddress[8:2]),
      .rdata_a (bus_word[i]),
      .raddr_b (byte_idx[8:2]),
      .rdata_b (stream_word[i])
    );
  end

  // Little-endian: the low two index bits pick the lane within the word.
  assign oSDDin = stream_word[byte_idx[1:0]];

  assign wReadData = (wReadEnable && buf_hit)  ? bus_word :
                     (wReadEnable && ctrl_hit) ? {29'b0, err, done, busy} :
                     32'hzzzz_zzzz;

  // Transfer sequencer with a per-handshake watchdog.
  always_ff @(posedge iCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      oSDWr      <= 1'b0;
      oSDAddress <= 32'h0;
      byte_idx   <= 9'd0;
      tmo_cnt    <= 24'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_seen   <= 1'b0;
    end else begin
      // Sticky: a reject anywhere in the transfer turns done into err.
      if (state != IDLE && iSDErr) err_seen <= 1'b1;

      if (state != IDLE && tmo_hit) begin
        state   <= IDLE;
        oSDWr   <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b0;
        err     <= 1'b1;
        tmo_cnt <= 24'd0;
      end else begin
        case (state)
          IDLE: begin
            if (trig) begin
              oSDAddress <= wWriteData;
              busy       <= 1'b1;
              done       <= 1'b0;
              err        <= 1'b0;
              err_seen   <= 1'b0;
              byte_idx   <= 9'd0;
              tmo_cnt    <= 24'd0;
              oSDWr      <= 1'b1;
              state      <= REQ;
            end
          end
          REQ: begin
            // Controller leaving idle means it accepted the request.
            if (!iSDIdle) begin
              state   <= SEND;
              tmo_cnt <= 24'd0;
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
          end
          SEND: begin
            if (iSDByteTaken) begin
              byte_idx <= byte_idx + 9'd1;
              tmo_cnt  <= 24'd0;
              if (byte_idx == 9'd511) begin
                state <= FINISH;
                oSDWr <= 1'b0;
              end
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
          end
          FINISH: begin
            if (iSDIdle) begin
              state   <= IDLE;
              busy    <= 1'b0;
              tmo_cnt <= 24'd0;
              if (err_seen || iSDErr) err  <= 1'b1;
              else                    done <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt + 24'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sd_write_interface.sv
// Bench for sd_write_interface: a simple SD controller model takes bytes with
// random gaps; a scoreboard compares the streamed bytes against a byte-level
// model of the sector buffer.
module tb_sd_write_interface;
  localparam logic [31:0] A_ADDR = 32'hFFFF_0260;
  localparam logic [31:0] A_CTRL = 32'hFFFF_0264;
  localparam logic [31:0] A_BUF  = 32'hFFFF_0400;

  logic        iCLK = 1'b0, Reset_n = 1'b0;
  logic        wReadEnable = 1'b0, wWriteEnable = 1'b0;
  logic [3:0]  wByteEnable = 4'h0;
  logic [31:0] wAddress = 32'h0, wWriteData = 32'h0;
  wire  [31:0] wReadData;
  logic        oSDWr;
  logic [31:0] oSDAddress;
  logic [7:0]  oSDDin;
  logic        iSDByteTaken, iSDIdle, iSDErr;

  sd_write_interface #(.TIMEOUT_CYCLES(24'd100)) dut (
    .iCLK(iCLK), .Reset_n(Reset_n), .wReadEnable(wReadEnable), .wWriteEnable(wWriteEnable),
    .wByteEnable(wByteEnable), .wAddress(wAddress), .wWriteData(wWriteData), .wReadData(wReadData),
    .oSDWr(oSDWr), .oSDAddress(oSDAddress), .oSDDin(oSDDin), .iSDByteTaken(iSDByteTaken),
    .iSDIdle(iSDIdle), .iSDErr(iSDErr));

  int tests = 0, fails = 0;
  int cyc = 0, last_take = 0, taken = 0, nbytes = 0;
  int stall_at = 1000, err_at = -1;
  logic [7:0] mb [512];       // sector contents as the CPU should see them
  logic [7:0] exp_q [$];

  initial forever #5 iCLK = ~iCLK;
  initial forever begin @(posedge iCLK); cyc++; end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h required %h", n, a, e);
    end
  endtask

  // Controller model: leave idle after a short delay, take bytes with random
  // gaps, optionally stall or flag a reject, then return to idle.
  initial begin
    int st, dly;
    st = 0; dly = 0;
    iSDIdle = 1'b1; iSDByteTaken = 1'b0; iSDErr = 1'b0;
    forever begin
      @(posedge iCLK); #1;
      iSDByteTaken = 1'b0; iSDErr = 1'b0;
      if (!Reset_n) begin
        st = 0; iSDIdle = 1'b1;
      end else begin
        case (st)
          0: if (oSDWr) begin taken = 0; dly = $urandom_range(0, 3); st = 1; end
          1: if (dly > 0) dly--; else begin iSDIdle = 1'b0; st = 2; end
          2: begin
            if (!oSDWr) begin dly = $urandom_range(1, 4); st = 3; end
            else if (taken < stall_at && $urandom_range(0, 2) != 0) begin
              iSDByteTaken = 1'b1;
              taken++;
              last_take = cyc;
              if (taken == err_at) iSDErr = 1'b1;
            end
          end
          default: if (dly > 0) dly--; else begin iSDIdle = 1'b1; st = 0; end
        endcase
      end
    end
  end

  // Scoreboard monitor: every byte the controller takes must be the next expected one.
  initial forever begin
    @(negedge iCLK);
    if (Reset_n && iSDByteTaken && oSDWr) begin
      logic [7:0] e;
      tests++;
      nbytes++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL byte_extra: got %h required no byte", oSDDin);
      end else begin
        e = exp_q.pop_front();
        if (oSDDin !== e) begin
          fails++;
          $display("FAIL byte_%0d: got %h required %h", nbytes - 1, oSDDin, e);
        end
      end
    end
  end

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wAddress = a; wWriteData = d; wByteEnable = be; wWriteEnable = 1'b1;
    @(posedge iCLK); #1;
    wWriteEnable = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] r);
    wAddress = a; wReadEnable = 1'b1;
    #1 r = wReadData;
    wReadEnable = 1'b0;
  endtask

  task automatic buf_wr(input int w, input logic [31:0] d, input logic [3:0] be, input bit busy_now);
    bus_wr(A_BUF + 32'(w * 4), d, be);
    if (!busy_now)
      for (int b = 0; b < 4; b++) if (be[b]) mb[w*4+b] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] mword(input int w);
    return {mb[w*4+3], mb[w*4+2], mb[w*4+1], mb[w*4]};
  endfunction

  task automatic trigger(input logic [31:0] sa);
    logic [31:0] r;
    for (int i = 0; i < 512; i++) exp_q.push_back(mb[i]);
    nbytes = 0;
    bus_wr(A_ADDR, sa, 4'hF);
    chk("wr_latency", {31'b0, oSDWr}, 32'd1);
    chk("sd_addr", oSDAddress, sa);
    bus_rd(A_CTRL, r);
    chk("status_busy", r, 32'h1);
  endtask

  task automatic wait_idle(input string n, input logic [31:0] st_exp, input int nb_exp);
    logic [31:0] r;
    bit ok;
    ok = 0;
    for (int i = 0; i < 6000; i++) begin
      @(posedge iCLK); #1;
      bus_rd(A_CTRL, r);
      if (!r[0]) begin ok = 1; break; end
    end
    if (!ok) begin
      fails++; tests++;
      $display("FAIL %s_idle: got busy after 6000 cycles required idle", n);
    end
    chk({n, "_status"}, r, st_exp);
    chk({n, "_nbytes"}, nbytes, nb_exp);
    if (nb_exp == 512) chk({n, "_q_empty"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (6) @(posedge iCLK);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    bit ok;
    // Reset values
    #1;
    bus_rd(A_CTRL, r);
    chk("rst_status", r, 32'h0);
    chk("rst_sdwr", {31'b0, oSDWr}, 32'd0);
    chk("rst_addr", oSDAddress, 32'h0);
    repeat (2) @(posedge iCLK);
    #1 Reset_n = 1'b1;
    @(posedge iCLK); #1;

    // Incrementing byte pattern, full sector
    for (int k = 0; k < 128; k++) buf_wr(k, 32'h0403_0201 + 32'(k) * 32'h0404_0404, 4'hF, 0);
    bus_rd(A_BUF, r);            chk("rd_w0", r, 32'h0403_0201);
    bus_rd(A_BUF + 32'h1FC, r);  chk("rd_w127", r, mword(127));
    trigger(32'h0000_0010);
    wait_idle("basic", 32'h2, 512);

    // Byte-enable write
    buf_wr(0, 32'h0, 4'hF, 0);
    buf_wr(0, 32'hAABB_CCDD, 4'b0100, 0);
    bus_rd(A_BUF, r);
    chk("byte_en", r, 32'h00BB_0000);

    // Writes while busy are ignored
    for (int k = 0; k < 128; k++) buf_wr(k, $urandom, 4'hF, 0);
    trigger(32'h0000_0020);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (taken >= 50) begin ok = 1; break; end
      @(posedge iCLK); #1;
    end
    chk("busy_reach", {31'b0, ok}, 32'd1);
    bus_wr(A_ADDR, 32'h0000_0099, 4'hF);
    chk("busy_addr", oSDAddress, 32'h0000_0020);
    buf_wr(5, $urandom, 4'hF, 1);
    bus_rd(A_BUF + 32'h14, r);
    chk("busy_buf", r, mword(5));
    bus_rd(A_CTRL, r);
    chk("busy_status", r, 32'h1);
    wait_idle("busy", 32'h2, 512);

    // Controller stalls after 100 bytes: watchdog fires 100 cycles after the
    // last accepted byte (one extra cycle for the pulse to be sampled).
    stall_at = 100;
    trigger(32'h0000_0030);
    ok = 0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge iCLK); #2;
      if (!oSDWr) begin ok = 1; break; end
    end
    chk("tmo_drop", {31'b0, ok}, 32'd1);
    chk("tmo_cycles", cyc - last_take, 32'd101);
    stall_at = 1000;
    @(posedge iCLK); #1;
    wait_idle("tmo", 32'h4, 100);

    // Reject mid-transfer, then reject coinciding with the final byte
    err_at = 300;
    trigger(32'h0000_0040);
    wait_idle("err_mid", 32'h4, 512);
    err_at = 512;
    trigger(32'h0000_0041);
    wait_idle("err_last", 32'h4, 512);
    err_at = -1;

    // Reset during byte 200 aborts immediately
    trigger(32'h0000_0050);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (taken >= 200) begin ok = 1; break; end
      @(posedge iCLK); #1;
    end
    chk("rst_reach", {31'b0, ok}, 32'd1);
    #1 Reset_n = 1'b0;
    #1 chk("rst_mid_sdwr", {31'b0, oSDWr}, 32'd0);
    bus_rd(A_CTRL, r);
    chk("rst_mid_status", r, 32'h0);
    chk("rst_mid_addr", oSDAddress, 32'h0);
    repeat (2) @(posedge iCLK);
    #1 Reset_n = 1'b1;
    exp_q.delete();
    repeat (8) @(posedge iCLK);
    #1;
    trigger(32'h0000_0051);
    wait_idle("restart", 32'h2, 512);

    // Random partial writes and transfers
    for (int t = 0; t < 3; t++) begin
      int w;
      for (int n = 0; n < 40; n++) buf_wr($urandom_range(0, 127), $urandom, 4'($urandom_range(0, 15)), 0);
      w = $urandom_range(0, 127);
      bus_rd(A_BUF + 32'(w * 4), r);
      chk("rand_rd", r, mword(w));
      trigger($urandom);
      wait_idle("rand", 32'h2, 512);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
